// File: rtl/elevator_scan_ctrl.sv
// ---------------------------------------------------------------------------
// elevator_scan_ctrl
//
// Clocked SCAN (collective) elevator controller. Floor calls are latched into
// a sticky pending mask, the car position is tracked from hoist arrival
// pulses, and calls are served in sweep order: the car keeps its direction
// while calls remain ahead of it. Each stop opens the door for DOOR_CYCLES
// cycles; an obstruction or a new call for the current floor restarts the
// dwell.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   fr         in   floor request bits (level or 1-cycle pulse)
//   arrive     in   1-cycle pulse: car reached the adjacent floor
//   door_block in   door obstruction, holds the door open
//   state      out  FSM state: WAIT=00, DOOR=01, UP=10, DOWN=11
//   cur_floor  out  current car floor
//   pending    out  latched, unserved requests
//   door_open  out  high exactly while state==DOOR
//
// Handshake note: there is no valid/ready pair here. fr is sampled every
// cycle and is never back-pressured; arrive is a fire-and-forget pulse that
// is only acted on while moving (UP/DOWN).
// ---------------------------------------------------------------------------
module elevator_scan_ctrl #(
    parameter int N_FLOORS    = 8,
    parameter int FLOOR_W     = 3,
    parameter int DOOR_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] fr,
    input  logic                arrive,
    input  logic                door_block,
    output logic [1:0]          state,
    output logic [FLOOR_W-1:0]  cur_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                door_open
);

    typedef enum logic [1:0] {
        S_WAIT = 2'b00,
        S_DOOR = 2'b01,
        S_UP   = 2'b10,
        S_DOWN = 2'b11
    } state_t;

    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] BOT_FLOOR = '0;
    localparam logic [FLOOR_W-1:0] ONE_FLOOR = FLOOR_W'(1);
    localparam logic [7:0]         DOOR_LOAD = 8'(DOOR_CYCLES);

    state_t                r_state;
    logic [FLOOR_W-1:0]    r_floor;
    logic [N_FLOORS-1:0]   r_pending;
    logic [7:0]            r_timer;
    logic                  r_dir;      // 0 = up, 1 = down

    state_t                w_next_state;
    logic [FLOOR_W-1:0]    w_next_floor;
    logic [7:0]            w_next_timer;
    logic                  w_next_dir;
    logic [N_FLOORS-1:0]   w_req;
    logic [N_FLOORS-1:0]   w_clr;
    logic                  w_above;
    logic                  w_below;
    logic                  w_here;
    logic [FLOOR_W-1:0]    w_up_floor;
    logic [FLOOR_W-1:0]    w_dn_floor;

    function automatic logic any_above(input logic [N_FLOORS-1:0] v,
                                       input logic [FLOOR_W-1:0]  f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i > int'(f) && v[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [N_FLOORS-1:0] v,
                                       input logic [FLOOR_W-1:0]  f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i < int'(f) && v[i]) r = 1'b1;
        end
        return r;
    endfunction

    // Same-cycle requests count, so a call arriving with arrive is a stop.
    assign w_req      = r_pending | fr;
    assign w_above    = any_above(w_req, r_floor);
    assign w_below    = any_below(w_req, r_floor);
    assign w_here     = w_req[r_floor];
    assign w_up_floor = r_floor + ONE_FLOOR;
    assign w_dn_floor = r_floor - ONE_FLOOR;

    always_comb begin
        w_next_state = r_state;
        w_next_floor = r_floor;
        w_next_timer = r_timer;
        w_next_dir   = r_dir;
        case (r_state)
            S_WAIT: begin
                if (w_here) begin
                    w_next_state = S_DOOR;
                    w_next_timer = DOOR_LOAD;
                end else if ((!r_dir && w_above) || (r_dir && !w_below && w_above)) begin
                    w_next_state = S_UP;
                    w_next_dir   = 1'b0;
                end else if (w_below) begin
                    w_next_state = S_DOWN;
                    w_next_dir   = 1'b1;
                end
            end
            S_UP: begin
                if (arrive) begin
                    if (r_floor == TOP_FLOOR) begin
                        // Top floor: no wrap, stop moving.
                        w_next_state = S_WAIT;
                    end else begin
                        w_next_floor = w_up_floor;
                        if (w_req[w_up_floor]) begin
                            w_next_state = S_DOOR;
                            w_next_timer = DOOR_LOAD;
                        end else if (!any_above(w_req, w_up_floor)) begin
                            w_next_state = S_WAIT;
                        end
                    end
                end
            end
            S_DOWN: begin
                if (arrive) begin
                    if (r_floor == BOT_FLOOR) begin
                        w_next_state = S_WAIT;
                    end else begin
                        w_next_floor = w_dn_floor;
                        if (w_req[w_dn_floor]) begin
                            w_next_state = S_DOOR;
                            w_next_timer = DOOR_LOAD;
                        end else if (!any_below(w_req, w_dn_floor)) begin
                            w_next_state = S_WAIT;
                        end
                    end
                end
            end
            S_DOOR: begin
                if (door_block || fr[r_floor]) begin
                    w_next_timer = DOOR_LOAD;
                end else if (r_timer <= 8'd1) begin
                    w_next_state = S_WAIT;
                    w_next_timer = 8'd0;
                end else begin
                    w_next_timer = r_timer - 8'd1;
                end
            end
            default: begin
                w_next_state = S_WAIT;
            end
        endcase
    end

    // The floor being served (entered or held in DOOR) is never left pending.
    always_comb begin
        w_clr = '0;
        if (w_next_state == S_DOOR) w_clr[w_next_floor] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_WAIT;
            r_floor   <= '0;
            r_pending <= '0;
            r_timer   <= 8'd0;
            r_dir     <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_floor   <= w_next_floor;
            r_pending <= (r_pending | fr) & ~w_clr;
            r_timer   <= w_next_timer;
            r_dir     <= w_next_dir;
        end
    end

    assign state     = r_state;
    assign cur_floor = r_floor;
    assign pending   = r_pending;
    assign door_open = (r_state == S_DOOR);

endmodule

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
- Clocked, parametrised successor to the combinational elevator next-direction logic.
- Latches hall/car calls into a sticky pending mask and tracks the car floor internally from arrival pulses.
- Serves calls in SCAN (collective) order with direction memory, and runs a door-dwell timer with obstruction hold.
- Sits between the call-button inputs and the hoist/door drive; the hoist reports each floor crossing via `arrive`.

Parameters:
- N_FLOORS, 8: number of floors; floors are numbered 0 to N_FLOORS-1.
- FLOOR_W, 3: width of the floor index; must satisfy 2^FLOOR_W >= N_FLOORS.
- DOOR_CYCLES, 4: number of clock cycles the door stays open per stop, 1 to 255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fr  in  N_FLOORS  floor-request bits; a level or a 1-cycle pulse, sampled every cycle.
- arrive  in  1  1-cycle pulse from the hoist: car reached the adjacent floor in the commanded direction.
- door_block  in  1  door obstruction; high holds the door open.
- state  out  2  WAIT=00, DOOR=01, UP=10, DOWN=11.
- cur_floor  out  FLOOR_W  current car floor.
- pending  out  N_FLOORS  latched, unserved requests.
- door_open  out  1  high exactly while state==DOOR.

Behaviour:
Reset:
- While rst is high, and immediately on its assertion (asynchronous), all of the following are 0: state=WAIT, cur_floor, pending, door_open, door timer, direction register (0 = up).
- The first rising edge after rst deasserts is active.

Request latching, every cycle:
- pending <= (pending | fr) & ~clear_mask.
- clear_mask holds the cur_floor bit (the arrival floor, on an arrive edge) when that edge enters or stays in DOOR.
- A request for the current floor while in DOOR is not latched; it reloads the door timer instead.

Definitions:
- above = any pending/fr bit above cur_floor.
- below = any such bit below cur_floor.
- here = pending[cur_floor] | fr[cur_floor].

State machine, all transitions registered, 1 cycle:
- WAIT:
  - If here: go to DOOR and load the timer with DOOR_CYCLES.
  - Else if dir=up and above, or dir=down and !below and above: go to UP with dir=up.
  - Else if below: go to DOWN with dir=down.
  - Else stay in WAIT.
  - `arrive` is ignored.
- UP:
  - On arrive: cur_floor += 1. If the new floor is requested (pending or fr), go to DOOR and load the timer. Otherwise stay in UP if anything is still above the new floor, else go to WAIT.
  - arrive while cur_floor==N_FLOORS-1 is ignored and the block goes to WAIT; the floor saturates and does not wrap.
- DOWN: mirror of UP with -1; saturates at floor 0.
- DOOR:
  - If door_block or fr[cur_floor]: reload the timer with DOOR_CYCLES.
  - Else decrement the timer.
  - When the timer is 1 and there is no reload: go to WAIT.
  - `arrive` is ignored.
  - Door-open time with no blocking is therefore exactly DOOR_CYCLES cycles.
- Direction register: updated only on entry to UP or DOWN. This gives SCAN behaviour: the car keeps its direction while calls remain ahead of it.

Simultaneous events:
- fr arriving on the same edge as an arrive makes that floor a stop.
- fr bits for other floors are latched during any state.
- Reset asserted mid-move or mid-door returns all outputs to their reset values immediately; pending calls are lost.

Test Plan:
- Basic trip:
  - Stimulus: reset; cur_floor=0; pulse fr=8'h04 for 1 cycle.
  - Required: next cycle state=UP and pending=8'h04; after arrive, cur_floor=1 and state=UP; after a second arrive, cur_floor=2, state=DOOR, pending=0 and door_open=1 for exactly 4 cycles; then state=WAIT.
- SCAN order:
  - Stimulus: car moving UP at floor 3; pulse fr=8'h22 (floors 5 and 1).
  - Required: the car continues up and stops at 5 (DOOR) first; then state=DOWN; stops at 1; pending=0 and final state=WAIT.
- Door hold:
  - Stimulus: door_block=1 for 10 cycles during DOOR, then release.
  - Required: door_open stays 1 throughout, then stays 1 for exactly 4 more cycles; fr[cur_floor] pulsed during DOOR also reloads the timer and leaves the pending bit 0.
- Current-floor call:
  - Stimulus: WAIT at floor 4; fr=8'h10.
  - Required: next cycle DOOR; cur_floor stays 4; no UP or DOWN ever asserted.
- Ignored/boundary arrivals:
  - Stimulus: arrive pulsed in WAIT and in DOOR; separately, arrive at floor 7 while UP (N_FLOORS=8).
  - Required: cur_floor is unchanged in the first case and stays 7 in the second; the block goes to WAIT, and 7 does not wrap to 0.
- Async reset mid-move:
  - Stimulus: with state=DOWN and pending=8'h81, assert rst between clock edges.
  - Required: state=00, pending=0, cur_floor=0 and door_open=0 before the next edge; rst must be held 2 cycles, after which operation resumes cleanly.
